// File: rtl/ft60x_fifo_master.sv
// ft60x_fifo_master
//   Bidirectional FT600/FT601 245-synchronous-FIFO bus master, clocked by the FTDI bus clock.
//   Moves user TX beats onto the DATA/BE pads and captures RX beats from the pads into a small
//   registered skid buffer. The top level owns the tristate pads; this block only produces the
//   output values and a single drive enable.
//
// Parameters
//   DATA_W     bus width, 32 (FT601) or 16 (FT600); byte-enable width is DATA_W/8
//   ARB_MODE   0 = round-robin, 1 = RX priority, 2 = TX priority
//   MAX_BURST  beats per burst before re-arbitration, 0 = unlimited (16-bit counter)
//   RX_DEPTH   RX skid buffer entries, power of two, >= 4
//
// Ports
//   clk_in, rst_n_in              FTDI bus clock, asynchronous active-low reset
//   txe_n_in, rxf_n_in            FTDI flow-control inputs
//   wr_n_out, rd_n_out, oe_n_out  FTDI strobes, registered
//   data_in/be_in                 pad input values
//   data_out/be_out, data_oe_out  pad output values and drive enable, registered
//   tx_data_in/tx_be_in/tx_valid_in/tx_ready_out   user TX beat stream
//   rx_data_out/rx_be_out/rx_valid_out/rx_ready_in user RX beat stream

module ft60x_fifo_master #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ARB_MODE  = 0,
    parameter int unsigned MAX_BURST = 256,
    parameter int unsigned RX_DEPTH  = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  txe_n_in,
    input  logic                  rxf_n_in,
    output logic                  wr_n_out,
    output logic                  rd_n_out,
    output logic                  oe_n_out,
    input  logic [DATA_W-1:0]     data_in,
    output logic [DATA_W-1:0]     data_out,
    output logic                  data_oe_out,
    input  logic [DATA_W/8-1:0]   be_in,
    output logic [DATA_W/8-1:0]   be_out,
    input  logic [DATA_W-1:0]     tx_data_in,
    input  logic [DATA_W/8-1:0]   tx_be_in,
    input  logic                  tx_valid_in,
    output logic                  tx_ready_out,
    output logic [DATA_W-1:0]     rx_data_out,
    output logic [DATA_W/8-1:0]   rx_be_out,
    output logic                  rx_valid_out,
    input  logic                  rx_ready_in
);

    localparam int unsigned BE_W = DATA_W / 8;
    localparam int unsigned AW   = $clog2(RX_DEPTH);
    localparam int unsigned EW   = DATA_W + BE_W;

    localparam logic [AW:0] DEPTH_C = (AW + 1)'(RX_DEPTH);
    localparam logic [AW:0] MARGIN  = (AW + 1)'(2);
    localparam logic [16:0] MAX_C   = 17'(MAX_BURST);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_TX    = 3'd1;
    localparam logic [2:0] S_RX_OE = 3'd2;
    localparam logic [2:0] S_RX    = 3'd3;
    localparam logic [2:0] S_TURN  = 3'd4;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]        state, state_nxt;
    logic              wr_n, wr_n_nxt;
    logic              rd_n, rd_n_nxt;
    logic              oe_n, oe_n_nxt;
    logic              data_oe, data_oe_nxt;
    logic [DATA_W-1:0] data_reg;
    logic [BE_W-1:0]   be_reg;
    logic [15:0]       burst_cnt, burst_nxt;
    logic              rr_rx, rr_nxt;  // 1: RX wins the next tie

    // RX skid buffer
    logic [EW-1:0]     rx_mem [RX_DEPTH];
    logic [AW-1:0]     rx_wptr;
    logic [AW-1:0]     rx_rptr;
    logic [AW:0]       rx_cnt;

    // ------------------------------------------------------------------
    // Datapath qualifiers
    // ------------------------------------------------------------------
    logic        hold_valid;
    logic        tx_accept;
    logic        rx_capture;
    logic        rx_pop;
    logic [AW:0] rx_free;
    logic        rx_room;
    logic [16:0] cnt_tx_next;
    logic [16:0] cnt_rx_next;
    logic        tx_cap_ok;
    logic        rx_cap_ok;
    logic        tx_load;
    logic        hold_next;
    logic        rx_continue;
    logic        rx_req;
    logic        tx_req;
    logic        grant_rx;
    logic        grant_tx;

    // The TX holding register is the data_out register itself; WR_N low marks it occupied.
    assign hold_valid = !wr_n;
    assign tx_accept  = (state == S_TX) && !wr_n && !txe_n_in;
    assign rx_capture = (state == S_RX) && !rd_n && !rxf_n_in;
    assign rx_pop     = rx_valid_out && rx_ready_in;

    // Free space ignores a same-cycle pop; the margin of two covers the beat that may
    // still be captured while the registered RD_N rises.
    assign rx_free = DEPTH_C - rx_cnt;
    assign rx_room = rx_free >= MARGIN;

    assign cnt_tx_next = {1'b0, burst_cnt} + {16'd0, tx_accept};
    assign cnt_rx_next = {1'b0, burst_cnt} + {16'd0, rx_capture};
    assign tx_cap_ok   = (MAX_BURST == 0) || (cnt_tx_next < MAX_C);
    assign rx_cap_ok   = (MAX_BURST == 0) || (cnt_rx_next < MAX_C);

    // Load only when the register will be empty after this edge and the burst has room.
    // With TXE_N high and the register empty nothing loads, which ends the burst.
    assign tx_load = (state == S_TX) && tx_valid_in && !txe_n_in && tx_cap_ok &&
                     (!hold_valid || tx_accept);
    assign hold_next = tx_load || (hold_valid && !tx_accept);

    assign rx_continue = !rxf_n_in && rx_room && rx_cap_ok;

    assign rx_req = !rxf_n_in && rx_room;
    assign tx_req = !txe_n_in && tx_valid_in;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    always_comb begin
        grant_rx = 1'b0;
        grant_tx = 1'b0;
        if (rx_req && tx_req) begin
            if (ARB_MODE == 1) begin
                grant_rx = 1'b1;
            end else if (ARB_MODE == 2) begin
                grant_tx = 1'b1;
            end else if (rr_rx) begin
                grant_rx = 1'b1;
            end else begin
                grant_tx = 1'b1;
            end
        end else begin
            grant_rx = rx_req;
            grant_tx = tx_req;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and strobe decode
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        wr_n_nxt    = 1'b1;
        rd_n_nxt    = 1'b1;
        oe_n_nxt    = 1'b1;
        data_oe_nxt = 1'b0;
        burst_nxt   = burst_cnt;
        rr_nxt      = rr_rx;

        case (state)
            S_IDLE: begin
                if (grant_rx) begin
                    state_nxt = S_RX_OE;
                    oe_n_nxt  = 1'b0;
                    burst_nxt = 16'd0;
                    rr_nxt    = 1'b0;
                end else if (grant_tx) begin
                    state_nxt   = S_TX;
                    data_oe_nxt = 1'b1;
                    burst_nxt   = 16'd0;
                    rr_nxt      = 1'b1;
                end
            end

            S_TX: begin
                burst_nxt = cnt_tx_next[15:0];
                if (hold_next) begin
                    wr_n_nxt    = 1'b0;
                    data_oe_nxt = 1'b1;
                end else begin
                    // Register drained and nothing more to send: release the bus.
                    state_nxt = S_TURN;
                end
            end

            S_RX_OE: begin
                // OE_N has been low for a cycle with the pads undriven; start reading.
                state_nxt = S_RX;
                oe_n_nxt  = 1'b0;
                rd_n_nxt  = !rx_continue;
            end

            S_RX: begin
                burst_nxt = cnt_rx_next[15:0];
                if (rd_n) begin
                    // RD_N went high last edge; any in-flight beat is captured, drop OE_N.
                    state_nxt = S_TURN;
                end else begin
                    oe_n_nxt = 1'b0;
                    rd_n_nxt = !rx_continue;
                end
            end

            S_TURN: begin
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Bus-side registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state     <= S_IDLE;
            wr_n      <= 1'b1;
            rd_n      <= 1'b1;
            oe_n      <= 1'b1;
            data_oe   <= 1'b0;
            data_reg  <= '0;
            be_reg    <= '0;
            burst_cnt <= 16'd0;
            rr_rx     <= 1'b1;
        end else begin
            state     <= state_nxt;
            wr_n      <= wr_n_nxt;
            rd_n      <= rd_n_nxt;
            oe_n      <= oe_n_nxt;
            data_oe   <= data_oe_nxt;
            burst_cnt <= burst_nxt;
            rr_rx     <= rr_nxt;
            if (tx_load) begin
                data_reg <= tx_data_in;
                be_reg   <= tx_be_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // RX skid buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rx_wptr <= '0;
            rx_rptr <= '0;
            rx_cnt  <= '0;
        end else begin
            if (rx_capture) begin
                rx_wptr <= rx_wptr + 1'b1;
            end
            if (rx_pop) begin
                rx_rptr <= rx_rptr + 1'b1;
            end
            case ({rx_capture, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + 1'b1;
                2'b01:   rx_cnt <= rx_cnt - 1'b1;
                default: rx_cnt <= rx_cnt;
            endcase
        end
    end

    // Storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge clk_in) begin
        if (rx_capture) begin
            rx_mem[rx_wptr] <= {be_in, data_in};
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wr_n_out     = wr_n;
    assign rd_n_out     = rd_n;
    assign oe_n_out     = oe_n;
    assign data_oe_out  = data_oe;
    assign data_out     = data_reg;
    assign be_out       = be_reg;
    assign tx_ready_out = tx_load;

    assign rx_valid_out = (rx_cnt != '0);
    assign rx_data_out  = rx_mem[rx_rptr][DATA_W-1:0];
    assign rx_be_out    = rx_mem[rx_rptr][EW-1:DATA_W];

endmodule

// File: tb/tb_ft60x_fifo_master.sv
// tb_ft60x_fifo_master
//   Directed bench for ft60x_fifo_master (32-bit bus, round-robin, 4-beat bursts, 4-entry RX
//   buffer). A small FTDI chip model feeds RX beats and records accepted TX beats; a user model
//   feeds TX beats and collects RX beats. Expected values are written out by hand.

module tb_ft60x_fifo_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        txe_n = 1'b0;
    logic        rxf_n = 1'b1;
    logic        wr_n, rd_n, oe_n;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        data_oe;
    logic [3:0]  be_in = '0;
    logic [3:0]  be_out;
    logic [31:0] tx_data = '0;
    logic [3:0]  tx_be = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic [3:0]  rx_be;
    logic        rx_valid;
    logic        rx_ready = 1'b1;

    logic [35:0] chip_q[$];   // beats the chip still has to deliver {be, data}
    logic [35:0] user_q[$];   // beats the user still has to send {be, data}
    logic [35:0] tx_seen[$];  // beats accepted on the bus
    logic [35:0] rx_got[$];   // beats handed to the user
    int          burst_dir[$];
    int          burst_beats[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_dir_changes = 0;

    always #5 clk = ~clk;

    ft60x_fifo_master #(
        .DATA_W    (32),
        .ARB_MODE  (0),
        .MAX_BURST (4),
        .RX_DEPTH  (4)
    ) dut (
        .clk_in       (clk),
        .rst_n_in     (rst_n),
        .txe_n_in     (txe_n),
        .rxf_n_in     (rxf_n),
        .wr_n_out     (wr_n),
        .rd_n_out     (rd_n),
        .oe_n_out     (oe_n),
        .data_in      (data_in),
        .data_out     (data_out),
        .data_oe_out  (data_oe),
        .be_in        (be_in),
        .be_out       (be_out),
        .tx_data_in   (tx_data),
        .tx_be_in     (tx_be),
        .tx_valid_in  (tx_valid),
        .tx_ready_out (tx_ready),
        .rx_data_out  (rx_data),
        .rx_be_out    (rx_be),
        .rx_valid_out (rx_valid),
        .rx_ready_in  (rx_ready)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Chip and user models: sample mid-cycle, act just after the rising edge.
    initial begin : bus_model
        logic        s_wr, s_rd, s_txt, s_rxt;
        logic [35:0] s_wbeat, s_rbeat;
        int          dir, prev_dir, last_dir;
        prev_dir = 0;
        last_dir = 0;
        forever begin
            @(negedge clk);
            s_wr    = !wr_n && !txe_n;
            s_wbeat = {be_out, data_out};
            s_rd    = !rd_n && !rxf_n;
            s_txt   = tx_valid && tx_ready;
            s_rxt   = rx_valid && rx_ready;
            s_rbeat = {rx_be, rx_data};
            dir     = data_oe ? 1 : (!oe_n ? 2 : 0);
            if (rst_n) begin
                if (!oe_n) check_eq("oe_low_bus_undriven", data_oe, 0);
                if (!wr_n) check_eq("wr_low_bus_driven", data_oe, 1);
                if (dir != 0 && prev_dir != 0) check_eq("dir_change_without_turn", dir, prev_dir);
                if (dir != 0 && prev_dir == 0) begin
                    burst_dir.push_back(dir);
                    burst_beats.push_back(0);
                end
                if (dir != 0 && last_dir != 0 && dir != last_dir) n_dir_changes++;
                if (dir != 0) last_dir = dir;
                prev_dir = dir;
            end else begin
                prev_dir = 0;
            end

            @(posedge clk);
            #1;
            if (s_wr) begin
                tx_seen.push_back(s_wbeat);
                if (burst_beats.size() > 0)
                    burst_beats[burst_beats.size()-1] = burst_beats[burst_beats.size()-1] + 1;
            end
            if (s_rd && chip_q.size() > 0) begin
                void'(chip_q.pop_front());
                if (burst_beats.size() > 0)
                    burst_beats[burst_beats.size()-1] = burst_beats[burst_beats.size()-1] + 1;
            end
            if (s_txt && user_q.size() > 0) void'(user_q.pop_front());
            if (s_rxt) rx_got.push_back(s_rbeat);

            if (chip_q.size() > 0) begin
                rxf_n = 1'b0;
                {be_in, data_in} = chip_q[0];
            end else begin
                rxf_n = 1'b1;
                {be_in, data_in} = '0;
            end
            if (user_q.size() > 0) begin
                tx_valid = 1'b1;
                {tx_be, tx_data} = user_q[0];
            end else begin
                tx_valid = 1'b0;
                {tx_be, tx_data} = '0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [35:0] exp_q[$];
        int          pending;

        // ---------------- reset state ----------------
        step(3);
        check_eq("rst_wr_n", wr_n, 1);
        check_eq("rst_rd_n", rd_n, 1);
        check_eq("rst_oe_n", oe_n, 1);
        check_eq("rst_data_oe", data_oe, 0);
        check_eq("rst_data_out", data_out, 0);
        check_eq("rst_be_out", be_out, 0);
        check_eq("rst_rx_valid", rx_valid, 0);
        check_eq("rst_tx_ready", tx_ready, 0);
        rst_n = 1'b1;
        step(2);

        // ---------------- round-robin with both sides pending ----------------
        burst_dir.delete();
        burst_beats.delete();
        for (int i = 0; i < 8; i++) begin
            chip_q.push_back({4'hF, 32'hC0 + 32'(i)});
            user_q.push_back({4'hF, 32'hD0 + 32'(i)});
        end
        for (int k = 0; k < 400 && !(tx_seen.size() == 8 && rx_got.size() == 8); k++) step(1);
        check_eq("arb_done", (tx_seen.size() == 8 && rx_got.size() == 8), 1);
        step(4);
        check_eq("arb_burst_count", burst_dir.size(), 4);
        for (int i = 0; i < 4 && i < burst_dir.size(); i++) begin
            check_eq("arb_burst_dir", burst_dir[i], (i % 2 == 0) ? 2 : 1);
            check_eq("arb_burst_beats", burst_beats[i], 4);
        end
        for (int i = 0; i < tx_seen.size(); i++)
            check_eq("arb_tx_order", tx_seen[i], {4'hF, 32'hD0 + 32'(i)});
        for (int i = 0; i < rx_got.size(); i++)
            check_eq("arb_rx_order", rx_got[i], {4'hF, 32'hC0 + 32'(i)});
        tx_seen.delete();
        rx_got.delete();

        // ---------------- TX only, 10 beats ----------------
        for (int i = 1; i <= 10; i++) user_q.push_back({4'hF, 32'(i)});
        for (int k = 0; k < 300 && tx_seen.size() < 10; k++) step(1);
        step(5);
        check_eq("tx1_beat_count", tx_seen.size(), 10);
        for (int i = 0; i < tx_seen.size(); i++)
            check_eq("tx1_order", tx_seen[i], {4'hF, 32'(i + 1)});
        tx_seen.delete();

        // ---------------- TXE_N high for 3 cycles at beat 5 ----------------
        for (int i = 1; i <= 10; i++) user_q.push_back({4'h3, 32'h10 + 32'(i)});
        for (int k = 0; k < 300 && !(!wr_n && data_out == 32'h15); k++) step(1);
        check_eq("tx2_beat5_on_pads", (!wr_n && data_out == 32'h15), 1);
        txe_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step(1);
            check_eq("tx2_hold_data", data_out, 32'h15);
            check_eq("tx2_hold_wr_n", wr_n, 0);
        end
        txe_n = 1'b0;
        for (int k = 0; k < 300 && tx_seen.size() < 10; k++) step(1);
        step(5);
        check_eq("tx2_beat_count", tx_seen.size(), 10);
        for (int i = 0; i < tx_seen.size(); i++)
            check_eq("tx2_order", tx_seen[i], {4'h3, 32'h11 + 32'(i)});
        tx_seen.delete();

        // ---------------- RX 8 beats, user stalls after 2 ----------------
        for (int i = 0; i < 8; i++) chip_q.push_back({4'(i + 1), 32'hA0 + 32'(i)});
        for (int k = 0; k < 300 && rx_got.size() < 2; k++) step(1);
        rx_ready = 1'b0;
        step(30);
        pending = 8 - chip_q.size() - rx_got.size();
        check_eq("rx3_stall_rd_n", rd_n, 1);
        check_eq("rx3_stall_valid", rx_valid, 1);
        check_eq("rx3_no_overflow", (pending >= 1 && pending <= 4), 1);
        check_eq("rx3_bus_stalled", (chip_q.size() >= 2), 1);
        rx_ready = 1'b1;
        for (int k = 0; k < 400 && rx_got.size() < 8; k++) step(1);
        check_eq("rx3_beat_count", rx_got.size(), 8);
        for (int i = 0; i < rx_got.size(); i++)
            check_eq("rx3_order", rx_got[i], {4'(i + 1), 32'hA0 + 32'(i)});
        rx_got.delete();

        // ---------------- reset during an RX burst ----------------
        for (int i = 0; i < 12; i++) chip_q.push_back({4'hA, 32'hE0 + 32'(i)});
        for (int k = 0; k < 50 && rd_n; k++) step(1);
        check_eq("rst6_rx_started", rd_n, 0);
        step(1);
        rst_n = 1'b0;
        #1;
        check_eq("rst6_wr_n", wr_n, 1);
        check_eq("rst6_rd_n", rd_n, 1);
        check_eq("rst6_oe_n", oe_n, 1);
        check_eq("rst6_data_oe", data_oe, 0);
        check_eq("rst6_rx_valid", rx_valid, 0);
        step(3);
        rst_n = 1'b1;
        exp_q = chip_q;
        rx_got.delete();
        for (int k = 0; k < 400 && rx_got.size() < exp_q.size(); k++) step(1);
        step(5);
        check_eq("rst6_chip_drained", chip_q.size(), 0);
        check_eq("rst6_beat_count", rx_got.size(), exp_q.size());
        for (int i = 0; i < rx_got.size() && i < exp_q.size(); i++)
            check_eq("rst6_order", rx_got[i], exp_q[i]);

        check_eq("turn_dir_changes_seen", (n_dir_changes >= 3), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
